// File: rtl/pipe_pkg.sv
// Shared types for the E/M/W control pipeline: writeback source, forward select, stage records.
package pipe_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic [4:0]  rd;
    } ctrl_m_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        result_src_e result_src;
        logic [4:0]  rd;
    } ctrl_w_t;

endpackage

// File: rtl/fwd_sel.sv
// Operand forward select for one E-stage source register; the M stage wins over W.
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       valid_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_m,
    input  logic       valid_w,
    input  logic       reg_write_w,
    input  logic [4:0] rd_w,
    output fwd_sel_e   sel
);

    always_comb begin
        sel = FWD_RF;
        if (valid_m && reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (valid_w && reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/cu_emw_pipe.sv
// E->M->W control pipeline with hazard detection and forwarding.
// Optional retired-instruction counter enabled by the CU_RETIRE_CNT_EN macro.
module cu_emw_pipe
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ValidE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             JumpE,
    input  logic             BranchE,
    input  logic             ZeroE,
    input  logic [1:0]       ResultSrcE,
    input  logic [4:0]       RdE,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic             StallM,
    output logic             RegWriteM,
    output logic [1:0]       ResultSrcM,
    output logic             MemWriteM,
    output logic [4:0]       RdM,
    output logic             RegWriteW,
    output logic [1:0]       ResultSrcW,
    output logic [4:0]       RdW,
    output logic             PCSrcE,
    output logic             StallFD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE
`ifdef CU_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] RetireCnt
`endif
);

    ctrl_m_t  m_q;
    ctrl_w_t  w_q;
    ctrl_m_t  e_ctrl;
    logic     load_stall;
    fwd_sel_e fwd_a;
    fwd_sel_e fwd_b;

    always_comb begin
        e_ctrl            = '0;
        e_ctrl.valid      = ValidE;
        e_ctrl.reg_write  = RegWriteE;
        e_ctrl.result_src = result_src_e'(ResultSrcE);
        e_ctrl.mem_write  = MemWriteE;
        e_ctrl.rd         = RdE;
    end

    // A memory stall freezes M and drains a bubble into W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= '0;
            w_q <= '0;
        end else if (!StallM) begin
            m_q <= e_ctrl;
            w_q <= '{valid: m_q.valid, reg_write: m_q.reg_write,
                     result_src: m_q.result_src, rd: m_q.rd};
        end else begin
            w_q <= '0;
        end
    end

    assign RegWriteM  = m_q.reg_write;
    assign ResultSrcM = m_q.result_src;
    assign MemWriteM  = m_q.mem_write & m_q.valid;
    assign RdM        = m_q.rd;
    assign RegWriteW  = w_q.reg_write & w_q.valid;
    assign ResultSrcW = w_q.result_src;
    assign RdW        = w_q.rd;

    assign load_stall = ValidE && (ResultSrcE == RES_MEM) && RegWriteE && (RdE != 5'd0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));

    // Redirect only when E actually advances, so a stalled branch fires once.
    assign PCSrcE  = ValidE & (JumpE | (BranchE & ZeroE)) & ~StallM;
    assign StallE  = StallM;
    assign StallFD = StallM | load_stall;
    assign FlushD  = PCSrcE;
    assign FlushE  = (PCSrcE | load_stall) & ~StallM;

    fwd_sel u_fwd_a (
        .rs          (Rs1E),
        .valid_m     (m_q.valid),
        .reg_write_m (m_q.reg_write),
        .rd_m        (m_q.rd),
        .valid_w     (w_q.valid),
        .reg_write_w (w_q.reg_write),
        .rd_w        (w_q.rd),
        .sel         (fwd_a)
    );

    fwd_sel u_fwd_b (
        .rs          (Rs2E),
        .valid_m     (m_q.valid),
        .reg_write_m (m_q.reg_write),
        .rd_m        (m_q.rd),
        .valid_w     (w_q.valid),
        .reg_write_w (w_q.reg_write),
        .rd_w        (w_q.rd),
        .sel         (fwd_b)
    );

    assign ForwardAE = fwd_a;
    assign ForwardBE = fwd_b;

`ifdef CU_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else if (w_q.valid) begin
            retire_cnt_q <= retire_cnt_q + 1'b1;
        end
    end

    assign RetireCnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_cu_emw_pipe.sv
// Self-checking bench for cu_emw_pipe: hazard/forward vector table, W-stage scoreboard,
// stall, reset and (with CU_RETIRE_CNT_EN) retire-counter sequences.
module tb_cu_emw_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ZeroE;
    logic [1:0] ResultSrcE;
    logic [4:0] RdE, Rs1E, Rs2E, Rs1D, Rs2D;
    logic       StallM;
    logic       RegWriteM, MemWriteM, RegWriteW;
    logic [1:0] ResultSrcM, ResultSrcW;
    logic [4:0] RdM, RdW;
    logic       PCSrcE, StallFD, StallE, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

`ifdef CU_RETIRE_CNT_EN
    logic [31:0] RetireCnt;
    logic [3:0]  RetireCnt4;
    logic        rw_m4, mw_m4, rw_w4, pcs4, sfd4, se4, fd4, fe4;
    logic [1:0]  rs_m4, rs_w4, fa4, fb4;
    logic [4:0]  rd_m4, rd_w4;

    // Narrow-counter copy shares all stimulus to exercise wrap-around.
    cu_emw_pipe #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .ValidE(ValidE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE), .ZeroE(ZeroE),
        .ResultSrcE(ResultSrcE), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .Rs1D(Rs1D),
        .Rs2D(Rs2D), .StallM(StallM), .RegWriteM(rw_m4), .ResultSrcM(rs_m4),
        .MemWriteM(mw_m4), .RdM(rd_m4), .RegWriteW(rw_w4), .ResultSrcW(rs_w4), .RdW(rd_w4),
        .PCSrcE(pcs4), .StallFD(sfd4), .StallE(se4), .FlushD(fd4), .FlushE(fe4),
        .ForwardAE(fa4), .ForwardBE(fb4), .RetireCnt(RetireCnt4)
    );
`endif

    cu_emw_pipe #(.CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .ValidE(ValidE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE), .ZeroE(ZeroE),
        .ResultSrcE(ResultSrcE), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .Rs1D(Rs1D),
        .Rs2D(Rs2D), .StallM(StallM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .RdM(RdM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .RdW(RdW), .PCSrcE(PCSrcE), .StallFD(StallFD), .StallE(StallE), .FlushD(FlushD),
        .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
`ifdef CU_RETIRE_CNT_EN
        , .RetireCnt(RetireCnt)
`endif
    );

    typedef struct {
        logic       p2_rw;
        logic [4:0] p2_rd;
        logic       p1_v;
        logic       p1_rw;
        logic [4:0] p1_rd;
        logic       v, rw, jmp, br, zero;
        logic [1:0] res;
        logic [4:0] rd, rs1e, rs2e, rs1d, rs2d;
        logic [1:0] x_fa, x_fb;
        logic       x_sfd, x_fe, x_fd;
    } vec_t;

    typedef struct {
        logic       rw;
        logic [1:0] res;
        logic [4:0] rd;
    } wexp_t;

    vec_t  vecs[13];
    wexp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_e(input logic v, input logic rw, input logic mw, input logic [1:0] res,
                           input logic [4:0] rd);
        ValidE = v; RegWriteE = rw; MemWriteE = mw; ResultSrcE = res; RdE = rd;
    endtask

    task automatic clear_in();
        drive_e(1'b0, 1'b0, 1'b0, 2'b00, 5'd0);
        JumpE = 0; BranchE = 0; ZeroE = 0;
        Rs1E = 0; Rs2E = 0; Rs1D = 0; Rs2D = 0; StallM = 0;
    endtask

    initial begin
        //          p2rw p2rd p1v p1rw p1rd v  rw jmp br z  res    rd  rs1e rs2e rs1d rs2d fa     fb     sfd fe fd
        vecs[0]  = '{1'b0, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd8, 5'd5, 5'd0, 5'd0, 5'd0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd8, 5'd5, 5'd0, 5'd0, 5'd0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd8, 5'd5, 5'd5, 5'd0, 5'd0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd8, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd8, 5'd5, 5'd9, 5'd0, 5'd0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 5'd6, 5'd0, 5'd0, 5'd1, 5'd6, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 5'd6, 5'd0, 5'd0, 5'd6, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 5'd6, 5'd0, 5'd0, 5'd6, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 5'd6, 5'd0, 5'd0, 5'd0, 5'd6, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1};

        clear_in();
        rst_n = 1'b0;
        #12;
        check("reset_regwrite_m", {31'd0, RegWriteM}, 32'd0);
        check("reset_rd_w", {27'd0, RdW}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hazard and forwarding vectors
        foreach (vecs[i]) begin
            drive_e(1'b1, vecs[i].p2_rw, 1'b0, 2'b00, vecs[i].p2_rd);
            tick();
            drive_e(vecs[i].p1_v, vecs[i].p1_rw, 1'b0, 2'b00, vecs[i].p1_rd);
            tick();
            drive_e(vecs[i].v, vecs[i].rw, 1'b0, vecs[i].res, vecs[i].rd);
            JumpE = vecs[i].jmp; BranchE = vecs[i].br; ZeroE = vecs[i].zero;
            Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e; Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d;
            #1;
            check($sformatf("vec%0d_fwd_a", i), {30'd0, ForwardAE}, {30'd0, vecs[i].x_fa});
            check($sformatf("vec%0d_fwd_b", i), {30'd0, ForwardBE}, {30'd0, vecs[i].x_fb});
            check($sformatf("vec%0d_stall_fd", i), {31'd0, StallFD}, {31'd0, vecs[i].x_sfd});
            check($sformatf("vec%0d_flush_e", i), {31'd0, FlushE}, {31'd0, vecs[i].x_fe});
            check($sformatf("vec%0d_flush_d", i), {31'd0, FlushD}, {31'd0, vecs[i].x_fd});
            check($sformatf("vec%0d_pcsrc", i), {31'd0, PCSrcE}, {31'd0, vecs[i].x_fd});
            clear_in();
        end

        // Random stream through the pipeline, W stage checked via scoreboard
        begin
            logic exp_mw;
            sb.delete();
            for (int n = 0; n < 24; n++) begin
                wexp_t   e;
                logic    v, rw, mw;
                logic [1:0] res;
                logic [4:0] rd;
                v = 1'($urandom_range(1)); rw = 1'($urandom_range(1));
                mw = 1'($urandom_range(1)); res = 2'($urandom_range(2)); rd = 5'($urandom);
                drive_e(v, rw, mw, res, rd);
                e.rw = v & rw; e.res = res; e.rd = rd;
                sb.push_back(e);
                exp_mw = v & mw;
                tick();
                check("stream_mem_write_m", {31'd0, MemWriteM}, {31'd0, exp_mw});
                check("stream_rd_m", {27'd0, RdM}, {27'd0, rd});
                if (sb.size() == 2) begin
                    e = sb.pop_front();
                    check("stream_reg_write_w", {31'd0, RegWriteW}, {31'd0, e.rw});
                    check("stream_result_src_w", {30'd0, ResultSrcW}, {30'd0, e.res});
                    check("stream_rd_w", {27'd0, RdW}, {27'd0, e.rd});
                end
            end
            sb.delete();
            clear_in();
            tick();
        end

        // Branch held by StallM redirects once, when it advances
        ValidE = 1; BranchE = 1; ZeroE = 1; StallM = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("beq_stall_pcsrc", {31'd0, PCSrcE}, 32'd0);
            check("beq_stall_flush_e", {31'd0, FlushE}, 32'd0);
            check("beq_stall_stall_e", {31'd0, StallE}, 32'd1);
            tick();
        end
        StallM = 0;
        #1;
        check("beq_go_pcsrc", {31'd0, PCSrcE}, 32'd1);
        check("beq_go_flush_d", {31'd0, FlushD}, 32'd1);
        check("beq_go_flush_e", {31'd0, FlushE}, 32'd1);
        tick();
        clear_in();
        #1;
        check("beq_after_pcsrc", {31'd0, PCSrcE}, 32'd0);

        // Store held in M during a memory stall
        drive_e(1'b1, 1'b1, 1'b0, 2'b00, 5'd3);
        tick();
        drive_e(1'b1, 1'b0, 1'b1, 2'b00, 5'd0);
        tick();
        check("sw_pre_reg_write_w", {31'd0, RegWriteW}, 32'd1);
        check("sw_pre_mem_write_m", {31'd0, MemWriteM}, 32'd1);
        StallM = 1;
        drive_e(1'b1, 1'b1, 1'b0, 2'b00, 5'd9);
        for (int c = 0; c < 2; c++) begin
            tick();
            check("sw_stall_mem_write_m", {31'd0, MemWriteM}, 32'd1);
            check("sw_stall_reg_write_w", {31'd0, RegWriteW}, 32'd0);
            check("sw_stall_rd_m", {27'd0, RdM}, 32'd0);
        end
        StallM = 0;
        tick();
        check("sw_after_rd_m", {27'd0, RdM}, 32'd9);
        check("sw_after_mem_write_m", {31'd0, MemWriteM}, 32'd0);
        check("sw_after_reg_write_w", {31'd0, RegWriteW}, 32'd0);

        // Asynchronous reset in the middle of a stall
        drive_e(1'b1, 1'b1, 1'b1, 2'b10, 5'd4);
        tick();
        tick();
        StallM = 1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_reg_write_m", {31'd0, RegWriteM}, 32'd0);
        check("rst_mem_write_m", {31'd0, MemWriteM}, 32'd0);
        check("rst_rd_m", {27'd0, RdM}, 32'd0);
        check("rst_result_src_m", {30'd0, ResultSrcM}, 32'd0);
        check("rst_reg_write_w", {31'd0, RegWriteW}, 32'd0);
        check("rst_rd_w", {27'd0, RdW}, 32'd0);
        check("rst_result_src_w", {30'd0, ResultSrcW}, 32'd0);
        clear_in();
        Rs1E = 5'd4;
        #1;
        check("rst_fwd_a", {30'd0, ForwardAE}, 32'd0);
        check("rst_stall_fd", {31'd0, StallFD}, 32'd0);
        check("rst_flush_e", {31'd0, FlushE}, 32'd0);
`ifdef CU_RETIRE_CNT_EN
        check("rst_retire_cnt", RetireCnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        clear_in();

`ifdef CU_RETIRE_CNT_EN
        drive_e(1'b1, 1'b1, 1'b0, 2'b00, 5'd1);
        repeat (10) tick();
        clear_in();
        repeat (3) tick();
        check("retire_cnt_10", RetireCnt, 32'd10);
        drive_e(1'b1, 1'b0, 1'b0, 2'b00, 5'd0);
        repeat (7) tick();
        clear_in();
        repeat (3) tick();
        check("retire_cnt_17", RetireCnt, 32'd17);
        check("retire_cnt4_wrap", {28'd0, RetireCnt4}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
